seq_cla_subtractor: RTL

//   Multi-cycle subtractor: Diff = A - B - Bin, one BLOCK_SIZE-bit borrow-lookahead block per clock.

---
 rtl/seq_cla_subtractor_pkg.sv | 15 +
 rtl/seq_cla_subtractor_bla.sv | 38 +++
 rtl/seq_cla_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_cla_subtractor_pkg.sv
// Shared types and sizing helpers for the multi-cycle borrow-lookahead subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Block counter width: $clog2(n), never below one bit so NUM_BLOCKS==1 still has a counter.
  function automatic int unsigned blk_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_cla_subtractor_bla.sv
// Combinational BLOCK_SIZE-bit borrow-lookahead block: d = a - b - bin, bout = block borrow-out.
module bla_block #(
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic [BLOCK_SIZE-1:0] a,
  input  logic [BLOCK_SIZE-1:0] b,
  input  logic                  bin,
  output logic [BLOCK_SIZE-1:0] d,
  output logic                  bout
);

  logic [BLOCK_SIZE-1:0] w_g;
  logic [BLOCK_SIZE-1:0] w_p;
  logic [BLOCK_SIZE:0]   w_c;
  logic                  w_term;

  // Each borrow is a flat sum of products of generates and propagates, not a ripple chain.
  always_comb begin
    w_g    = ~a & b;
    w_p    = ~(a ^ b);
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = bin;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      w_term = bin;
      for (int k = 0; k <= i; k++) w_term = w_term & w_p[k];
      w_c[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) w_term = w_term & w_p[k];
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
    d    = a ^ b ^ w_c[BLOCK_SIZE-1:0];
    bout = w_c[BLOCK_SIZE];
  end

endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle subtractor Diff = A - B - Bin, resolving one BLOCK_SIZE-bit slice per clock
// through a single shared borrow-lookahead block, with a valid/ready handshake on both sides.
module seq_cla_subtractor
  import seq_sub_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned NUM_BLOCKS = WIDTH / BLOCK_SIZE;
  localparam int unsigned BLK_W      = blk_w(NUM_BLOCKS);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  if ((WIDTH % BLOCK_SIZE) != 0) begin : g_bad_cfg
    $error("seq_cla_subtractor: WIDTH must be a multiple of BLOCK_SIZE");
  end

  state_t                r_state;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      r_diff;
  logic                  r_borrow;
  logic                  r_bout;
  logic                  r_ovf;
  logic [BLK_W-1:0]      r_blk;

  logic [BLOCK_SIZE-1:0] w_a_sl;
  logic [BLOCK_SIZE-1:0] w_b_sl;
  logic [BLOCK_SIZE-1:0] w_d_sl;
  logic                  w_bout;

  // Operand slice mux feeding the shared block.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
      if (r_blk == BLK_W'(i)) begin
        w_a_sl = r_a[i*BLOCK_SIZE +: BLOCK_SIZE];
        w_b_sl = r_b[i*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  bla_block #(.BLOCK_SIZE(BLOCK_SIZE)) u_bla (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .bin  (r_borrow),
    .d    (w_d_sl),
    .bout (w_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_blk    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_blk    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
            if (r_blk == BLK_W'(i)) r_diff[i*BLOCK_SIZE +: BLOCK_SIZE] <= w_d_sl;
          end
          r_borrow <= w_bout;
          r_blk    <= r_blk + BLK_W'(1);
          // The top slice's MSB is the result sign, so overflow resolves in the same edge.
          if (r_blk == LAST_BLK) begin
            r_bout  <= w_bout;
            r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d_sl[BLOCK_SIZE-1] ^ r_a[WIDTH-1]);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Diff      = r_diff;
  assign Bout      = r_bout;
  assign Ovf       = r_ovf;

endmodule
